// File: rtl/axi_rom_rd_slave.sv
// AXI4 read-only responder backed by a word memory with a backdoor preload port.
// Serves single-beat, INCR and FIXED bursts after a fixed first-beat latency.
module axi_rom_rd_slave #(
  parameter logic [31:0] ADDR_BASE  = 32'h1c00_0000,
  parameter int          MEM_WORDS  = 1024,
  parameter int          ID_W       = 4,
  parameter int          RD_LATENCY = 2,
  localparam int         AW         = $clog2(MEM_WORDS)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [ID_W-1:0] arid,
  input  logic [31:0]     araddr,
  input  logic [7:0]      arlen,
  input  logic [2:0]      arsize,
  input  logic [1:0]      arburst,
  input  logic            arvalid,
  output logic            arready,
  output logic [ID_W-1:0] rid,
  output logic [31:0]     rdata,
  output logic [1:0]      rresp,
  output logic            rlast,
  output logic            rvalid,
  input  logic            rready,
  input  logic            init_we,
  input  logic [AW-1:0]   init_addr,
  input  logic [31:0]     init_wdata
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_BURST = 2'd2} state_t;

  localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 1);

  logic [31:0]     r_mem [MEM_WORDS];
  state_t          r_state, w_state_nxt;
  logic            r_arready, w_arready_nxt;
  logic            r_rvalid, w_rvalid_nxt;
  logic            r_rlast, w_rlast_nxt;
  logic [ID_W-1:0] r_rid, w_rid_nxt;
  logic [31:0]     r_rdata, w_rdata_nxt;
  logic [1:0]      r_rresp, w_rresp_nxt;
  logic [3:0]      r_lat, w_lat_nxt;
  logic [7:0]      r_beat, w_beat_nxt;
  logic [7:0]      r_len, w_len_nxt;
  logic [31:0]     r_widx, w_widx_nxt;
  logic            r_slverr, w_slverr_nxt;
  logic            r_fixed, w_fixed_nxt;

  logic            w_ar_hs, w_r_hs, w_in_range, w_below;
  logic [31:0]     w_off;
  logic [33:0]     w_beat;
  logic            w_unused;

  // {resp, data} for one beat; protocol errors dominate range errors.
  function automatic logic [33:0] beat_f(input logic slverr, input logic in_range,
                                         input logic [31:0] word);
    if (slverr) begin
      beat_f = {2'b10, 32'h0000_0000};
    end else if (!in_range) begin
      beat_f = {2'b11, 32'h0000_0000};
    end else begin
      beat_f = {2'b00, word};
    end
  endfunction

  assign w_ar_hs    = arvalid & r_arready;
  assign w_r_hs     = r_rvalid & rready;
  assign w_below    = (araddr < ADDR_BASE);
  assign w_off      = araddr - ADDR_BASE;
  // Bit 31 flags an address below the base; bit 30 is headroom so INCR never wraps.
  assign w_in_range = (r_widx[31:AW] == {(32-AW){1'b0}});
  assign w_beat     = beat_f(r_slverr, w_in_range, r_mem[r_widx[AW-1:0]]);
  assign w_unused   = ^w_off[1:0];

  // Backdoor preload port, independent of reset and FSM state.
  always_ff @(posedge clk) begin
    if (init_we) begin
      r_mem[init_addr] <= init_wdata;
    end
  end

  // Next-state and next-output logic for the AR/R handshake sequencer.
  always_comb begin
    w_state_nxt   = r_state;
    w_arready_nxt = r_arready;
    w_rvalid_nxt  = r_rvalid;
    w_rlast_nxt   = r_rlast;
    w_rid_nxt     = r_rid;
    w_rdata_nxt   = r_rdata;
    w_rresp_nxt   = r_rresp;
    w_lat_nxt     = r_lat;
    w_beat_nxt    = r_beat;
    w_len_nxt     = r_len;
    w_widx_nxt    = r_widx;
    w_slverr_nxt  = r_slverr;
    w_fixed_nxt   = r_fixed;
    case (r_state)
      S_IDLE: begin
        w_arready_nxt = 1'b1;
        if (w_ar_hs) begin
          w_arready_nxt = 1'b0;
          w_rid_nxt     = arid;
          w_len_nxt     = arlen;
          w_beat_nxt    = 8'd0;
          w_widx_nxt    = {w_below, 1'b0, w_off[31:2]};
          w_slverr_nxt  = (arsize != 3'b010) || (arburst == 2'b10);
          w_fixed_nxt   = (arburst == 2'b00);
          w_lat_nxt     = LAT_INIT;
          w_state_nxt   = S_WAIT;
        end else begin
          w_state_nxt   = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_lat == 4'd0) begin
          w_rvalid_nxt = 1'b1;
          w_rdata_nxt  = w_beat[31:0];
          w_rresp_nxt  = w_beat[33:32];
          w_rlast_nxt  = (r_beat == r_len);
          w_beat_nxt   = r_beat + 8'd1;
          w_widx_nxt   = r_fixed ? r_widx : (r_widx + 32'd1);
          w_state_nxt  = S_BURST;
        end else begin
          w_lat_nxt    = r_lat - 4'd1;
        end
      end
      S_BURST: begin
        if (w_r_hs && r_rlast) begin
          w_rvalid_nxt  = 1'b0;
          w_rlast_nxt   = 1'b0;
          w_arready_nxt = 1'b1;
          w_state_nxt   = S_IDLE;
        end else if (w_r_hs) begin
          w_rdata_nxt   = w_beat[31:0];
          w_rresp_nxt   = w_beat[33:32];
          w_rlast_nxt   = (r_beat == r_len);
          w_beat_nxt    = r_beat + 8'd1;
          w_widx_nxt    = r_fixed ? r_widx : (r_widx + 32'd1);
        end else begin
          w_state_nxt   = S_BURST;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= {ID_W{1'b0}};
      r_rdata   <= 32'h0000_0000;
      r_rresp   <= 2'b00;
      r_lat     <= 4'd0;
      r_beat    <= 8'd0;
      r_len     <= 8'd0;
      r_widx    <= 32'd0;
      r_slverr  <= 1'b0;
      r_fixed   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rlast   <= w_rlast_nxt;
      r_rid     <= w_rid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_rresp   <= w_rresp_nxt;
      r_lat     <= w_lat_nxt;
      r_beat    <= w_beat_nxt;
      r_len     <= w_len_nxt;
      r_widx    <= w_widx_nxt;
      r_slverr  <= w_slverr_nxt;
      r_fixed   <= w_fixed_nxt;
    end
  end

  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rlast   = r_rlast;
  assign rid     = r_rid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

endmodule

// File: tb/tb_axi_rom_rd_slave.sv
// Scoreboard bench for axi_rom_rd_slave: directed AR requests push expected beats,
// a negedge monitor pops and compares every accepted R beat.
module tb_axi_rom_rd_slave;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  arid = 4'h0;
  logic [31:0] araddr = 32'h0;
  logic [7:0]  arlen = 8'h0;
  logic [2:0]  arsize = 3'b010;
  logic [1:0]  arburst = 2'b01;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        init_we = 1'b0;
  logic [9:0]  init_addr = 10'h0;
  logic [31:0] init_wdata = 32'h0;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    rr_mode = 0;
  logic  held_v = 1'b0;
  beat_t held_b;

  axi_rom_rd_slave #(
    .ADDR_BASE(32'h1c00_0000), .MEM_WORDS(1024), .ID_W(4), .RD_LATENCY(2)
  ) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // rready pattern: 0 = always high, 1 = toggling, otherwise low
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0: rready = 1'b1;
      1: rready = ~rready;
      default: rready = 1'b0;
    endcase
  end

  // monitor: stability while stalled, scoreboard compare on each accepted beat
  always @(negedge clk) begin
    if (!resetn) begin
      held_v = 1'b0;
    end else begin
      if (held_v && rvalid) chk("hold", 64'({rid, rdata, rresp, rlast}), 64'(held_b));
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got data %h resp %b, none expected", rdata, rresp);
        end else begin
          chk("beat", 64'({rid, rdata, rresp, rlast}), 64'(exp_q.pop_front()));
        end
        held_v = 1'b0;
      end else if (rvalid) begin
        held_v = 1'b1;
        held_b = beat_t'({rid, rdata, rresp, rlast});
      end else begin
        held_v = 1'b0;
      end
    end
  end

  task automatic bd_write(input int idx, input logic [31:0] d);
    init_we = 1'b1; init_addr = idx[9:0]; init_wdata = d;
    @(posedge clk); #1;
    init_we = 1'b0;
  endtask

  task automatic push(input logic [3:0] id, input logic [31:0] d, input logic [1:0] r, input logic l);
    exp_q.push_back(beat_t'({id, d, r, l}));
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu);
    bit ok = 1'b0;
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL ar_timeout: got arready=0 for 50 cycles, expected 1");
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rvalid) begin ok = 1'b0; ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d beats pending rvalid=%b, expected 0", exp_q.size(), rvalid);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    // preload during reset
    bd_write(0, 32'h0280_3c0c);
    bd_write(2, 32'h0000_abcd);
    bd_write(4, 32'h11); bd_write(5, 32'h0bad_0005);
    bd_write(6, 32'h33); bd_write(7, 32'h44);
    bd_write(5, 32'h22);
    for (int i = 8; i < 12; i++) bd_write(i, 32'h8000_0000 + 32'(i));
    bd_write(1023, 32'hcafe_f00d);
    for (int i = 0; i < 256; i++) bd_write(512 + i, {16'ha5a5, 16'(i)});

    @(negedge clk);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_rid_rdata_rresp", 64'({rid, rdata, rresp}), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("arready_pre_edge", 64'(arready), 64'd0);
    @(negedge clk);
    chk("arready_first_edge", 64'(arready), 64'd1);
    @(posedge clk); #1;

    // single beat with latency and arready return checks
    rr_mode = 0;
    push(4'h5, 32'h0280_3c0c, 2'b00, 1'b1);
    send_ar(4'h5, 32'h1c00_0000, 8'd0, 3'b010, 2'b01);
    @(negedge clk); chk("arready_drop", 64'(arready), 64'd0); chk("lat_c0", 64'(rvalid), 64'd0);
    @(negedge clk); chk("lat_c1", 64'(rvalid), 64'd0);
    @(negedge clk); chk("lat_c2", 64'(rvalid), 64'd1);
    @(negedge clk); chk("arready_back", 64'(arready), 64'd1); chk("rvalid_off", 64'(rvalid), 64'd0);
    @(posedge clk); #1;
    drain();

    // INCR with toggling back-pressure
    rr_mode = 1;
    push(4'h1, 32'h11, 2'b00, 1'b0); push(4'h1, 32'h22, 2'b00, 1'b0);
    push(4'h1, 32'h33, 2'b00, 1'b0); push(4'h1, 32'h44, 2'b00, 1'b1);
    send_ar(4'h1, 32'h1c00_0010, 8'd3, 3'b010, 2'b01);
    drain();

    // FIXED
    rr_mode = 0;
    for (int i = 0; i < 3; i++) push(4'h2, 32'h0000_abcd, 2'b00, i == 2);
    send_ar(4'h2, 32'h1c00_0008, 8'd2, 3'b010, 2'b00);
    drain();

    // errors: bad size, WRAP, top overflow, below base, SLVERR over DECERR
    push(4'h3, 32'h0, 2'b10, 1'b0); push(4'h3, 32'h0, 2'b10, 1'b1);
    send_ar(4'h3, 32'h1c00_0000, 8'd1, 3'b001, 2'b01);
    drain();
    push(4'h4, 32'h0, 2'b10, 1'b1);
    send_ar(4'h4, 32'h1c00_0000, 8'd0, 3'b010, 2'b10);
    drain();
    push(4'h6, 32'hcafe_f00d, 2'b00, 1'b0); push(4'h6, 32'h0, 2'b11, 1'b1);
    send_ar(4'h6, 32'h1c00_0ffc, 8'd1, 3'b010, 2'b01);
    drain();
    push(4'h7, 32'h0, 2'b11, 1'b1);
    send_ar(4'h7, 32'h1b00_0000, 8'd0, 3'b010, 2'b01);
    drain();
    push(4'h8, 32'h0, 2'b10, 1'b1);
    send_ar(4'h8, 32'h1b00_0000, 8'd0, 3'b011, 2'b01);
    drain();

    // 256-beat INCR
    rr_mode = 1;
    for (int i = 0; i < 256; i++) push(4'h9, {16'ha5a5, 16'(i)}, 2'b00, i == 255);
    send_ar(4'h9, 32'h1c00_0800, 8'd255, 3'b010, 2'b01);
    drain();

    // reset during the second beat of a 4-beat burst
    rr_mode = 0;
    push(4'ha, 32'h8000_0008, 2'b00, 1'b0); push(4'ha, 32'h8000_0009, 2'b00, 1'b0);
    send_ar(4'ha, 32'h1c00_0020, 8'd3, 3'b010, 2'b01);
    @(posedge clk); @(posedge clk); @(posedge clk);
    @(negedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("midrst_rvalid", 64'(rvalid), 64'd0);
    chk("midrst_arready", 64'(arready), 64'd0);
    chk("midrst_rlast", 64'(rlast), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("postrst_arready", 64'(arready), 64'd1);
    repeat (6) @(negedge clk);
    chk("postrst_no_stale", 64'(rvalid), 64'd0);
    chk("postrst_queue", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;

    // backdoor write colliding with the beat load: old data returned
    push(4'hb, 32'h22, 2'b00, 1'b1);
    send_ar(4'hb, 32'h1c00_0014, 8'd0, 3'b010, 2'b01);
    @(posedge clk); #1;
    bd_write(5, 32'h55);
    drain();
    push(4'hc, 32'h55, 2'b00, 1'b1);
    send_ar(4'hc, 32'h1c00_0014, 8'd0, 3'b010, 2'b01);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
